// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: memory stage between EX and WB of the five-stage pipeline.
// Performs sized loads and stores (B/H/W, and D when XLEN=64) over a req/ack
// data-memory port with variable latency. It extends loads (sign or zero),
// merges store bytes into lanes, stalls EX while an access is outstanding,
// and registers the write-back value chosen by wb_select.
//
// Ports:
//   sys_clk, sys_rst              clock, synchronous active-high reset
//   in_valid / in_ready           EX handshake (transfer on in_valid & in_ready)
//   wb_select, pc_plus_4, alu_res write-back mux select and its sources
//   rs2_data                      store data
//   mem_read, mem_write           access type (write wins if both are set)
//   mem_size, load_unsigned       access size (B/H/W/D), load zero-extension
//   dmem_req/we/addr/wdata/wstrb  registered bus request, held until ack
//   dmem_ack, dmem_rdata          one-cycle completion and read data
//   out_valid, wb_data, misalign  registered result pulse to WB
module mem_stage_lsu #(
    parameter int XLEN   = 64,
    parameter int LANE_W = $clog2(XLEN / 8)
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          wb_select,
    input  logic [XLEN-1:0]     pc_plus_4,
    input  logic [XLEN-1:0]     alu_res,
    input  logic [XLEN-1:0]     rs2_data,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic [1:0]          mem_size,
    input  logic                load_unsigned,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic [XLEN-1:0]     dmem_addr,
    output logic [XLEN-1:0]     dmem_wdata,
    output logic [XLEN/8-1:0]   dmem_wstrb,
    input  logic                dmem_ack,
    input  logic [XLEN-1:0]     dmem_rdata,
    output logic                out_valid,
    output logic [XLEN-1:0]     wb_data,
    output logic                misalign
);

    localparam int NB = XLEN / 8;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t state_q, state_d;

    // Access context captured at launch, consumed when the ack returns.
    logic [1:0]        sel_p1;
    logic [XLEN-1:0]   alu_p1;
    logic [XLEN-1:0]   pc4_p1;
    logic [1:0]        size_p1;
    logic              uns_p1;
    logic [LANE_W-1:0] off_p1;

    logic              req_d, we_d, vld_d, mis_d;
    logic [XLEN-1:0]   addr_d, wdata_d, wb_d;
    logic [NB-1:0]     wstrb_d;

    logic              is_mem, bad_access, launch;

    function automatic logic [NB-1:0] size_mask(input logic [1:0] sz);
        logic [NB-1:0] m;
        m = '0;
        for (int i = 0; i < NB; i++) m[i] = (i < (1 << sz));
        return m;
    endfunction

    // Misaligned address, or a doubleword on a 32-bit datapath.
    function automatic logic is_illegal(input logic [2:0] a, input logic [1:0] sz);
        logic [2:0] am;
        case (sz)
            2'b00:   am = 3'b000;
            2'b01:   am = 3'b001;
            2'b10:   am = 3'b011;
            default: am = 3'b111;
        endcase
        return ((a & am) != 3'b000) || ((sz == 2'b11) && (XLEN == 32));
    endfunction

    // Shift the addressed bytes to bit 0, then extend by pushing the field to
    // the top and shifting back (arithmetic for signed, logical for unsigned).
    function automatic logic [XLEN-1:0] fmt_load(input logic [XLEN-1:0] rd,
                                                 input logic [LANE_W-1:0] off,
                                                 input logic [1:0] sz,
                                                 input logic uns);
        logic [XLEN-1:0]        raw;
        logic signed [XLEN-1:0] top;
        int                     sh;
        raw = rd >> {off, 3'b000};
        sh  = XLEN - (8 << sz);
        if (sh < 0) sh = 0;
        top = $signed(raw << sh);
        if (uns) return (raw << sh) >> sh;
        return top >>> sh;
    endfunction

    function automatic logic [XLEN-1:0] wb_mux(input logic [1:0] sel,
                                               input logic [XLEN-1:0] alu,
                                               input logic [XLEN-1:0] ld,
                                               input logic [XLEN-1:0] pc4);
        case (sel)
            2'b01:   return ld;
            2'b10:   return pc4;
            default: return alu;
        endcase
    endfunction

    assign in_ready   = (state_q == IDLE);
    assign is_mem     = mem_read | mem_write;
    assign bad_access = is_illegal(alu_res[2:0], mem_size);
    assign launch     = in_ready & in_valid & is_mem & ~bad_access;

    always_comb begin
        state_d = state_q;
        req_d   = dmem_req;
        we_d    = dmem_we;
        addr_d  = dmem_addr;
        wdata_d = dmem_wdata;
        wstrb_d = dmem_wstrb;
        vld_d   = 1'b0;
        mis_d   = 1'b0;
        wb_d    = wb_data;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (!is_mem) begin
                        vld_d = 1'b1;
                        wb_d  = wb_mux(wb_select, alu_res, '0, pc_plus_4);
                    end else if (bad_access) begin
                        vld_d = 1'b1;
                        mis_d = 1'b1;
                        wb_d  = '0;
                    end else begin
                        state_d = BUSY;
                        req_d   = 1'b1;
                        we_d    = mem_write;
                        addr_d  = {alu_res[XLEN-1:LANE_W], {LANE_W{1'b0}}};
                        if (mem_write) begin
                            wdata_d = rs2_data << {alu_res[LANE_W-1:0], 3'b000};
                            wstrb_d = size_mask(mem_size) << alu_res[LANE_W-1:0];
                        end else begin
                            wdata_d = '0;
                            wstrb_d = '0;
                        end
                    end
                end
            end
            BUSY: begin
                if (dmem_ack) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    addr_d  = '0;
                    wdata_d = '0;
                    wstrb_d = '0;
                    vld_d   = 1'b1;
                    wb_d    = wb_mux(sel_p1, alu_p1,
                                     fmt_load(dmem_rdata, off_p1, size_p1, uns_p1),
                                     pc4_p1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Stage boundary: launch context held for the duration of the access.
    always_ff @(posedge sys_clk) begin
        if (launch) begin
            sel_p1  <= wb_select;
            alu_p1  <= alu_res;
            pc4_p1  <= pc_plus_4;
            size_p1 <= mem_size;
            uns_p1  <= load_unsigned;
            off_p1  <= alu_res[LANE_W-1:0];
        end
    end

    // Stage boundary: registered bus request and write-back outputs.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            dmem_wstrb <= '0;
            out_valid  <= 1'b0;
            wb_data    <= '0;
            misalign   <= 1'b0;
        end else begin
            dmem_req   <= req_d;
            dmem_we    <= we_d;
            dmem_addr  <= addr_d;
            dmem_wdata <= wdata_d;
            dmem_wstrb <= wstrb_d;
            out_valid  <= vld_d;
            wb_data    <= wb_d;
            misalign   <= mis_d;
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

    typedef struct packed {
        logic        mis;
        logic [63:0] data;
    } exp_t;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  wb_select = 2'b00;
    logic [63:0] pc_plus_4 = '0;
    logic [63:0] alu_res = '0;
    logic [63:0] rs2_data = '0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [1:0]  mem_size = 2'b00;
    logic        load_unsigned = 1'b0;
    logic        dmem_req, dmem_we;
    logic [63:0] dmem_addr, dmem_wdata;
    logic [7:0]  dmem_wstrb;
    logic        dmem_ack = 1'b0;
    logic [63:0] dmem_rdata = '0;
    logic        out_valid, misalign;
    logic [63:0] wb_data;

    // 32-bit instance, used only for the doubleword-illegal case.
    logic        in_valid32 = 1'b0;
    logic        in_ready32, req32, we32, vld32, mis32;
    logic [31:0] pc32, alu32, rs232, addr32, wdata32, wb32;
    logic [3:0]  wstrb32;
    assign pc32  = pc_plus_4[31:0];
    assign alu32 = alu_res[31:0];
    assign rs232 = rs2_data[31:0];

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    always #5 sys_clk = ~sys_clk;

    mem_stage_lsu #(.XLEN(64)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .wb_select(wb_select), .pc_plus_4(pc_plus_4), .alu_res(alu_res),
        .rs2_data(rs2_data), .mem_read(mem_read), .mem_write(mem_write),
        .mem_size(mem_size), .load_unsigned(load_unsigned),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .out_valid(out_valid), .wb_data(wb_data), .misalign(misalign)
    );

    mem_stage_lsu #(.XLEN(32)) dut32 (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .in_valid(in_valid32), .in_ready(in_ready32),
        .wb_select(wb_select), .pc_plus_4(pc32), .alu_res(alu32),
        .rs2_data(rs232), .mem_read(mem_read), .mem_write(mem_write),
        .mem_size(mem_size), .load_unsigned(load_unsigned),
        .dmem_req(req32), .dmem_we(we32), .dmem_addr(addr32),
        .dmem_wdata(wdata32), .dmem_wstrb(wstrb32),
        .dmem_ack(1'b0), .dmem_rdata(32'h0),
        .out_valid(vld32), .wb_data(wb32), .misalign(mis32)
    );

    task automatic test_reset();
        sys_rst  = 1'b1;
        dmem_ack = 1'b1;
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        checks++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb, out_valid, wb_data, misalign} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: req=%0b we=%0b addr=%h wdata=%h wstrb=%h vld=%0b wb=%h mis=%0b, want all zero",
                     dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb, out_valid, wb_data, misalign);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        @(negedge sys_clk);
        checks++;
        if ({dmem_req, out_valid, in_ready} !== 3'b001) begin
            errors++;
            $display("FAIL idle_ack_ignored: req/vld/rdy=%b want 001", {dmem_req, out_valid, in_ready});
        end
        @(posedge sys_clk); #1;
        dmem_ack = 1'b0;
    endtask

    task automatic test_alu_back_to_back();
        exp_t e;
        @(posedge sys_clk); #1;
        in_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
        wb_select = 2'b00; alu_res = 64'h1234;
        exp_q.push_back({1'b0, 64'h1234});
        @(posedge sys_clk); #1;
        alu_res = 64'h5678;
        exp_q.push_back({1'b0, 64'h5678});
        @(negedge sys_clk);
        checks++;
        e = exp_q.pop_front();
        if ({out_valid, misalign, wb_data} !== {1'b1, e.mis, e.data}) begin
            errors++;
            $display("FAIL alu_first: vld=%b mis=%b wb=%h want vld=1 mis=%b wb=%h", out_valid, misalign, wb_data, e.mis, e.data);
        end
        @(posedge sys_clk); #1;
        wb_select = 2'b10; pc_plus_4 = 64'h8000_0004;
        exp_q.push_back({1'b0, 64'h8000_0004});
        @(negedge sys_clk);
        checks++;
        e = exp_q.pop_front();
        if ({out_valid, misalign, wb_data} !== {1'b1, e.mis, e.data}) begin
            errors++;
            $display("FAIL alu_second: vld=%b mis=%b wb=%h want vld=1 mis=%b wb=%h", out_valid, misalign, wb_data, e.mis, e.data);
        end
        @(posedge sys_clk); #1;
        in_valid = 1'b0;
        @(negedge sys_clk);
        checks++;
        e = exp_q.pop_front();
        if ({out_valid, misalign, wb_data} !== {1'b1, e.mis, e.data}) begin
            errors++;
            $display("FAIL alu_pc_link: vld=%b mis=%b wb=%h want vld=1 mis=%b wb=%h", out_valid, misalign, wb_data, e.mis, e.data);
        end
        @(posedge sys_clk); #1;
        @(negedge sys_clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL alu_pulse_end: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_load_byte();
        exp_t e;
        for (int u = 0; u < 2; u++) begin
            @(posedge sys_clk); #1;
            in_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; mem_size = 2'b00;
            load_unsigned = (u == 1); alu_res = 64'h1003; wb_select = 2'b01;
            exp_q.push_back({1'b0, (u == 1) ? 64'h80 : 64'hFFFF_FFFF_FFFF_FF80});
            @(posedge sys_clk); #1;
            in_valid = 1'b0; mem_read = 1'b0;
            @(negedge sys_clk);
            checks++;
            if ({dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata, in_ready, out_valid} !==
                {1'b1, 1'b0, 64'h1000, 8'h00, 64'h0, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL lb_request[%0d]: req=%b we=%b addr=%h wstrb=%h wdata=%h rdy=%b vld=%b want 1 0 1000 00 0 0 0",
                         u, dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata, in_ready, out_valid);
            end
            dmem_ack = 1'b1; dmem_rdata = 64'h0000_0000_8000_0000;
            @(posedge sys_clk); #1;
            dmem_ack = 1'b0; dmem_rdata = '0;
            @(negedge sys_clk);
            checks++;
            e = exp_q.pop_front();
            if ({out_valid, misalign, wb_data, dmem_req, in_ready} !== {1'b1, e.mis, e.data, 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL lb_result[%0d]: vld=%b mis=%b wb=%h req=%b rdy=%b want 1 %b %h 0 1",
                         u, out_valid, misalign, wb_data, dmem_req, in_ready, e.mis, e.data);
            end
        end
    endtask

    task automatic test_store_slow_ack();
        exp_t e;
        @(posedge sys_clk); #1;
        in_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b1; mem_size = 2'b01;
        alu_res = 64'h2006; rs2_data = 64'hABCD; wb_select = 2'b00;
        exp_q.push_back({1'b0, 64'h2006});
        @(posedge sys_clk); #1;
        in_valid = 1'b0; mem_write = 1'b0; rs2_data = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge sys_clk);
            checks++;
            if ({dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata, in_ready, out_valid} !==
                {1'b1, 1'b1, 64'h2000, 8'hC0, 64'hABCD_0000_0000_0000, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL sh_hold[%0d]: req=%b we=%b addr=%h wstrb=%h wdata=%h rdy=%b vld=%b want 1 1 2000 c0 abcd000000000000 0 0",
                         k, dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata, in_ready, out_valid);
            end
            if (k == 2) dmem_ack = 1'b1;
            @(posedge sys_clk); #1;
            dmem_ack = 1'b0;
        end
        @(negedge sys_clk);
        checks++;
        e = exp_q.pop_front();
        if ({out_valid, misalign, wb_data} !== {1'b1, e.mis, e.data}) begin
            errors++;
            $display("FAIL sh_result: vld=%b mis=%b wb=%h want 1 %b %h", out_valid, misalign, wb_data, e.mis, e.data);
        end
        checks++;
        if ({dmem_req, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL sh_release: req=%b rdy=%b want 0 1", dmem_req, in_ready);
        end
    endtask

    task automatic test_misalign();
        exp_t e;
        @(posedge sys_clk); #1;
        in_valid = 1'b1; mem_read = 1'b1; mem_size = 2'b10; alu_res = 64'h1002; wb_select = 2'b01;
        exp_q.push_back({1'b1, 64'h0});
        @(posedge sys_clk); #1;
        in_valid = 1'b0; mem_read = 1'b0;
        @(negedge sys_clk);
        checks++;
        e = exp_q.pop_front();
        if ({out_valid, misalign, wb_data} !== {1'b1, e.mis, e.data}) begin
            errors++;
            $display("FAIL lw_misalign: vld=%b mis=%b wb=%h want 1 %b %h", out_valid, misalign, wb_data, e.mis, e.data);
        end
        checks++;
        if ({dmem_req, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL lw_misalign_bus: req=%b rdy=%b want 0 1", dmem_req, in_ready);
        end
        // LD on the 32-bit datapath: aligned address but illegal size.
        @(posedge sys_clk); #1;
        in_valid32 = 1'b1; mem_read = 1'b1; mem_size = 2'b11; alu_res = 64'h1000;
        @(posedge sys_clk); #1;
        in_valid32 = 1'b0; mem_read = 1'b0;
        @(negedge sys_clk);
        checks++;
        if ({vld32, mis32, wb32, req32, we32, addr32, wdata32, wstrb32, in_ready32} !==
            {1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1}) begin
            errors++;
            $display("FAIL ld_xlen32: vld=%b mis=%b wb=%h req=%b we=%b addr=%h wdata=%h wstrb=%h rdy=%b want 1 1 0 0 0 0 0 0 1",
                     vld32, mis32, wb32, req32, we32, addr32, wdata32, wstrb32, in_ready32);
        end
    endtask

    task automatic test_reset_mid_access();
        @(posedge sys_clk); #1;
        in_valid = 1'b1; mem_read = 1'b1; mem_size = 2'b11; alu_res = 64'h3000; wb_select = 2'b01;
        @(posedge sys_clk); #1;
        in_valid = 1'b0; mem_read = 1'b0;
        @(negedge sys_clk);
        checks++;
        if ({dmem_req, dmem_addr, in_ready} !== {1'b1, 64'h3000, 1'b0}) begin
            errors++;
            $display("FAIL ld_busy: req=%b addr=%h rdy=%b want 1 3000 0", dmem_req, dmem_addr, in_ready);
        end
        @(posedge sys_clk); #1;
        sys_rst = 1'b1;
        @(posedge sys_clk); #1;
        sys_rst = 1'b0; dmem_ack = 1'b1; dmem_rdata = 64'hDEAD_BEEF_0000_0001;
        for (int c = 0; c < 5; c++) begin
            @(negedge sys_clk);
            checks++;
            if ({dmem_req, out_valid, in_ready} !== 3'b001) begin
                errors++;
                $display("FAIL rst_abandon[%0d]: req=%b vld=%b rdy=%b want 0 0 1", c, dmem_req, out_valid, in_ready);
            end
            @(posedge sys_clk); #1;
            dmem_ack = 1'b0; dmem_rdata = '0;
        end
    endtask

    initial begin
        test_reset();
        test_alu_back_to_back();
        test_load_byte();
        test_store_slow_ack();
        test_misalign();
        test_reset_mid_access();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d results never produced, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
